wb_port_arbiter: RTL and testbench

Arbitrates the single register-file write port between the in-order MEM/WB pipeline stage and an out-of-band long-latency result source (multiply/divide unit, memory return). Pipeline writebacks have priority; out-of-band results wait in a small FIFO, and a starvation counter forces a pipeline stall so queued results drain. The block also reports pending-destination hits to decode, so source operands are not read before a queued result lands.

---
 rtl/wb_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the in-order MEM/WB
// stage and an out-of-band long-latency result source. Pipeline writebacks
// always win. Out-of-band results wait in a small in-order queue. If the queue
// head is starved for too long, the block asks the pipeline for a writeback
// bubble so the queue can drain.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   pipe_we/addr/data_i     MEM/WB writeback request
//   ext_valid/addr/data_i   out-of-band result offer
//   ext_ready_o             queue has room (depends on the current count only)
//   rs1/rs2_addr_i          decode-stage source registers
//   pend_hit1/2_o           a source register matches a queued destination
//   pipe_stall_o            request a writeback bubble (decoded from state)
//   rf_we/addr/data_o       registered register-file write port
//   proto_err_o             sticky: the pipeline wrote during a held stall
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | queue empty, starvation timer parked at its reload value
// ST_WAIT  | queue non-empty; timer counts down while the head is blocked
// ST_FORCE | head starved; stall asserted until the head is granted
module wb_port_arbiter #(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pipe_we_i,
  input  logic [ADDR_W-1:0] pipe_addr_i,
  input  logic [DATA_W-1:0] pipe_data_i,
  input  logic              ext_valid_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic [DATA_W-1:0] ext_data_i,
  output logic              ext_ready_o,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic              pend_hit1_o,
  output logic              pend_hit2_o,
  output logic              pipe_stall_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  output logic [DATA_W-1:0] rf_data_o,
  output logic              proto_err_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] STARVE_C = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [STV_W-1:0]  starve_left, starve_next;
  logic              force_prev;

  logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  q_count, q_count_next;

  logic              pipe_req, q_empty, push, pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign pipe_req    = pipe_we_i && (pipe_addr_i != '0);
  assign q_empty     = (q_count == '0);
  // Readiness ignores a same-cycle pop so a full queue never refills in the
  // cycle it drains.
  assign ext_ready_o = (q_count < DEPTH_C);
  assign push        = ext_valid_i && ext_ready_o;
  assign pop         = !pipe_req && !q_empty;
  assign head_addr   = q_addr[rd_ptr];
  assign head_data   = q_data[rd_ptr];
  assign pipe_stall_o = (state == ST_FORCE);

  always_comb begin
    q_count_next = q_count;
    if (push && !pop) begin
      q_count_next = q_count + 1'b1;
    end else if (pop && !push) begin
      q_count_next = q_count - 1'b1;
    end
  end

  // Starvation timer is a down-counter; the cycle it would reach zero is the
  // STARVE_LIMIT-th blocked cycle, which arms the forced stall.
  always_comb begin
    state_next  = state;
    starve_next = starve_left;
    case (state)
      ST_IDLE: begin
        starve_next = STARVE_C;
        if (push) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (pop) begin
          starve_next = STARVE_C;
          if (q_count_next == '0) state_next = ST_IDLE;
        end else if (pipe_req) begin
          starve_next = starve_left - 1'b1;
          if (starve_left == STV_W'(1)) state_next = ST_FORCE;
        end
      end
      ST_FORCE: begin
        if (pop) begin
          starve_next = STARVE_C;
          state_next  = (q_count_next == '0) ? ST_IDLE : ST_WAIT;
        end
      end
      default: begin
        state_next  = ST_IDLE;
        starve_next = STARVE_C;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      starve_left <= STARVE_C;
      force_prev  <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      q_count     <= '0;
      rf_we_o     <= 1'b0;
      rf_addr_o   <= '0;
      rf_data_o   <= '0;
      proto_err_o <= 1'b0;
    end else begin
      state       <= state_next;
      starve_left <= starve_next;
      force_prev  <= (state == ST_FORCE);
      q_count     <= q_count_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (pipe_req) begin
        rf_we_o   <= 1'b1;
        rf_addr_o <= pipe_addr_i;
        rf_data_o <= pipe_data_i;
      end else if (pop) begin
        // A queued x0 result is drained without touching the register file.
        rf_we_o   <= (head_addr != '0);
        rf_addr_o <= head_addr;
        rf_data_o <= head_data;
      end else begin
        rf_we_o <= 1'b0;
      end

      // The first FORCE cycle may still carry an in-flight writeback; only a
      // request in a later FORCE cycle breaks the stall handshake.
      if ((state == ST_FORCE) && force_prev && pipe_req) proto_err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_addr[wr_ptr] <= ext_addr_i;
      q_data[wr_ptr] <= ext_data_i;
    end
  end

  always_comb begin
    pend_hit1_o = 1'b0;
    pend_hit2_o = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (CNT_W'(i) < q_count) begin
        if ((rs1_addr_i != '0) && (q_addr[rd_ptr + PTR_W'(i)] == rs1_addr_i)) pend_hit1_o = 1'b1;
        if ((rs2_addr_i != '0) && (q_addr[rd_ptr + PTR_W'(i)] == rs2_addr_i)) pend_hit2_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed stimulus with literal checks, plus a
// queue-based reference model compared against the DUT on every negedge.
module tb_wb_port_arbiter;

  localparam int DATA_W       = 64;
  localparam int ADDR_W       = 5;
  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              pipe_we_i;
  logic [ADDR_W-1:0] pipe_addr_i;
  logic [DATA_W-1:0] pipe_data_i;
  logic              ext_valid_i;
  logic [ADDR_W-1:0] ext_addr_i;
  logic [DATA_W-1:0] ext_data_i;
  logic              ext_ready_o;
  logic [ADDR_W-1:0] rs1_addr_i;
  logic [ADDR_W-1:0] rs2_addr_i;
  logic              pend_hit1_o;
  logic              pend_hit2_o;
  logic              pipe_stall_o;
  logic              rf_we_o;
  logic [ADDR_W-1:0] rf_addr_o;
  logic [DATA_W-1:0] rf_data_o;
  logic              proto_err_o;

  always #5 clk_i = ~clk_i;

  wb_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pipe_we_i(pipe_we_i), .pipe_addr_i(pipe_addr_i), .pipe_data_i(pipe_data_i),
    .ext_valid_i(ext_valid_i), .ext_addr_i(ext_addr_i), .ext_data_i(ext_data_i),
    .ext_ready_o(ext_ready_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .pend_hit1_o(pend_hit1_o), .pend_hit2_o(pend_hit2_o),
    .pipe_stall_o(pipe_stall_o),
    .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o),
    .proto_err_o(proto_err_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              mq[$];
  ent_t              m_head;
  logic              m_ok = 1'b0;
  logic              m_we, m_err, m_force, m_force_prev, m_was_force;
  logic              m_req, m_accept, m_blocked_now, m_granted;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  int                m_blocked;

  function automatic logic m_hit(input logic [ADDR_W-1:0] rs);
    logic h;
    h = 1'b0;
    if (rs != '0) begin
      foreach (mq[i]) if (mq[i].addr == rs) h = 1'b1;
    end
    return h;
  endfunction

  initial begin
    forever begin
      @(negedge clk_i);
      if (m_ok) begin
        chk("rf_we", rf_we_o, m_we);
        if (m_we) begin
          chk("rf_addr", rf_addr_o, m_addr);
          chk("rf_data", rf_data_o, m_data);
        end
        chk("proto_err", proto_err_o, m_err);
        chk("ext_ready", ext_ready_o, mq.size() < FIFO_DEPTH);
        chk("pipe_stall", pipe_stall_o, m_force);
        chk("pend_hit1", pend_hit1_o, m_hit(rs1_addr_i));
        chk("pend_hit2", pend_hit2_o, m_hit(rs2_addr_i));
      end
      // advance the model across the coming rising edge
      if (rst_i) begin
        mq.delete();
        m_we = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0;
        m_force = 1'b0; m_force_prev = 1'b0; m_blocked = 0;
        m_ok = 1'b1;
      end else if (m_ok) begin
        m_accept      = ext_valid_i && (mq.size() < FIFO_DEPTH);
        m_req         = pipe_we_i && (pipe_addr_i != '0);
        m_blocked_now = 1'b0;
        m_granted     = 1'b0;
        m_was_force   = m_force;
        if (m_req && m_force && m_force_prev) m_err = 1'b1;
        if (m_req) begin
          m_we = 1'b1; m_addr = pipe_addr_i; m_data = pipe_data_i;
          m_blocked_now = (mq.size() != 0);
        end else if (mq.size() != 0) begin
          m_head = mq.pop_front();
          m_we = (m_head.addr != '0); m_addr = m_head.addr; m_data = m_head.data;
          m_granted = 1'b1;
        end else begin
          m_we = 1'b0;
        end
        if (m_granted) begin
          m_blocked = 0;
          m_force   = 1'b0;
        end else if (m_blocked_now && !m_force) begin
          m_blocked++;
          if (m_blocked >= STARVE_LIMIT) m_force = 1'b1;
        end
        m_force_prev = m_was_force;
        if (m_accept) mq.push_back({ext_addr_i, ext_data_i});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    pipe_we_i = 1'b0; pipe_addr_i = '0; pipe_data_i = '0;
    ext_valid_i = 1'b0; ext_addr_i = '0; ext_data_i = '0;
    rs1_addr_i = '0; rs2_addr_i = '0;

    // reset and first pipe write
    cyc(); cyc();
    chk("rst_rf_we", rf_we_o, 0);
    chk("rst_rf_addr", rf_addr_o, 0);
    chk("rst_rf_data", rf_data_o, 0);
    chk("rst_stall", pipe_stall_o, 0);
    chk("rst_proto", proto_err_o, 0);
    chk("rst_ready", ext_ready_o, 1);
    rst_i = 1'b0;
    pipe_we_i = 1'b1; pipe_addr_i = 5'd3; pipe_data_i = 64'hAA;
    cyc();
    pipe_we_i = 1'b0;
    chk("t1_we", rf_we_o, 1);
    chk("t1_addr", rf_addr_o, 3);
    chk("t1_data", rf_data_o, 64'hAA);
    cyc();
    chk("t1_we_off", rf_we_o, 0);

    // idle out-of-band result
    rs1_addr_i = 5'd7;
    ext_valid_i = 1'b1; ext_addr_i = 5'd7; ext_data_i = 64'h1234;
    #1;
    chk("t2_hit_before", pend_hit1_o, 0);
    cyc();
    ext_valid_i = 1'b0;
    chk("t2_hit_queued", pend_hit1_o, 1);
    chk("t2_we_n1", rf_we_o, 0);
    cyc();
    chk("t2_we_n2", rf_we_o, 1);
    chk("t2_addr", rf_addr_o, 7);
    chk("t2_data", rf_data_o, 64'h1234);
    chk("t2_hit_after", pend_hit1_o, 0);
    cyc();
    chk("t2_we_off", rf_we_o, 0);

    // starvation forces a stall
    ext_valid_i = 1'b1; ext_addr_i = 5'd9; ext_data_i = 64'h99;
    cyc();
    ext_valid_i = 1'b0;
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      pipe_we_i = 1'b1; pipe_addr_i = 5'd1; pipe_data_i = 64'h100 + 64'(i);
      chk("t3_stall_low", pipe_stall_o, 0);
      cyc();
    end
    chk("t3_stall_high", pipe_stall_o, 1);
    pipe_we_i = 1'b0;
    cyc();
    chk("t3_stall_drop", pipe_stall_o, 0);
    chk("t3_we", rf_we_o, 1);
    chk("t3_addr", rf_addr_o, 9);
    chk("t3_data", rf_data_o, 64'h99);
    cyc();

    // full queue, held third offer, order preserved
    pipe_we_i = 1'b1; pipe_addr_i = 5'd2; pipe_data_i = 64'h22;
    ext_valid_i = 1'b1; ext_addr_i = 5'd10; ext_data_i = 64'hA0;
    cyc();
    ext_addr_i = 5'd11; ext_data_i = 64'hB0;
    cyc();
    chk("t4_ready_full", ext_ready_o, 0);
    ext_addr_i = 5'd12; ext_data_i = 64'hC0;
    cyc();
    pipe_we_i = 1'b0;
    chk("t4_ready_pop", ext_ready_o, 0);
    cyc();
    chk("t4_ready_again", ext_ready_o, 1);
    chk("t4_first", rf_addr_o, 10);
    cyc();
    ext_valid_i = 1'b0;
    chk("t4_second", rf_addr_o, 11);
    cyc();
    chk("t4_third", rf_addr_o, 12);
    chk("t4_third_data", rf_data_o, 64'hC0);
    cyc();

    // x0 drop, then a stall violation
    ext_valid_i = 1'b1; ext_addr_i = 5'd0; ext_data_i = 64'h55;
    cyc();
    ext_valid_i = 1'b0;
    cyc();
    chk("t5_x0_no_we", rf_we_o, 0);
    ext_valid_i = 1'b1; ext_addr_i = 5'd13; ext_data_i = 64'hD0;
    cyc();
    ext_valid_i = 1'b0;
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      pipe_we_i = 1'b1; pipe_addr_i = 5'd1; pipe_data_i = 64'h200 + 64'(i);
      cyc();
    end
    chk("t5_force", pipe_stall_o, 1);
    pipe_addr_i = 5'd4; pipe_data_i = 64'h44;
    cyc();
    chk("t5_proto_legal", proto_err_o, 0);
    chk("t5_first_force_write", rf_addr_o, 4);
    pipe_addr_i = 5'd5; pipe_data_i = 64'h55;
    cyc();
    pipe_we_i = 1'b0;
    chk("t5_viol_we", rf_we_o, 1);
    chk("t5_viol_addr", rf_addr_o, 5);
    chk("t5_viol_data", rf_data_o, 64'h55);
    chk("t5_proto_set", proto_err_o, 1);
    cyc();
    chk("t5_drain_addr", rf_addr_o, 13);
    chk("t5_stall_off", pipe_stall_o, 0);
    cyc(); cyc();
    chk("t5_proto_sticky", proto_err_o, 1);

    // reset while in FORCE with two queued entries
    rs1_addr_i = 5'd14; rs2_addr_i = 5'd15;
    pipe_we_i = 1'b1; pipe_addr_i = 5'd2; pipe_data_i = 64'h22;
    ext_valid_i = 1'b1; ext_addr_i = 5'd14; ext_data_i = 64'hE0;
    cyc();
    ext_addr_i = 5'd15; ext_data_i = 64'hF0;
    cyc();
    ext_valid_i = 1'b0;
    cyc(); cyc(); cyc();
    chk("t6_force", pipe_stall_o, 1);
    chk("t6_hit1", pend_hit1_o, 1);
    chk("t6_hit2", pend_hit2_o, 1);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0; pipe_we_i = 1'b0;
    chk("t6_stall_cleared", pipe_stall_o, 0);
    chk("t6_hit1_cleared", pend_hit1_o, 0);
    chk("t6_hit2_cleared", pend_hit2_o, 0);
    chk("t6_proto_cleared", proto_err_o, 0);
    chk("t6_ready", ext_ready_o, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_stale_write", rf_we_o, 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
